// File: rtl/xy_vector_renderer.sv
// XY vector renderer: snapshots the game state once per frame and scans
// ball dot, paddle line and score tick marks as an X/Y DAC beam stream.
// The beam is blanked while it travels to the start of each element.
module xy_vector_renderer #(
    parameter int X_MAX           = 255,
    parameter int Y_MAX           = 220,
    parameter int PLATE_HALFWIDTH = 15,
    parameter int BALL_DWELL      = 16,
    parameter int SETTLE          = 2,
    parameter int SCORE_Y         = 240,
    parameter int SCORE_STEP      = 4,
    parameter int MAX_MARKS       = 63
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] x_b,
    input  logic [7:0] y_b,
    input  logic [7:0] y_p_mid,
    input  logic [7:0] score,
    output logic [7:0] dac_x,
    output logic [7:0] dac_y,
    output logic       blank,
    output logic       frame_start
);

    typedef enum logic [2:0] {
        SNAP,
        BALL_MOVE,
        BALL,
        PAD_MOVE,
        PAD,
        MARK_MOVE,
        MARK
    } state_t;

    state_t     state;
    logic [4:0] cnt;
    logic [7:0] snap_x;
    logic [7:0] snap_y;
    logic [7:0] pmin;
    logic [7:0] pmax;
    logic [7:0] pad_y;
    logic [5:0] marks;
    logic [5:0] idx;

    // Lower paddle end, saturated at the bottom of the screen.
    function automatic logic [7:0] paddle_min(input logic [7:0] c);
        if (c >= 8'(PLATE_HALFWIDTH))
            return c - 8'(PLATE_HALFWIDTH);
        else
            return 8'd0;
    endfunction

    // Upper paddle end, saturated at the top of the playfield.
    function automatic logic [7:0] paddle_max(input logic [7:0] c);
        if (c <= 8'(Y_MAX - PLATE_HALFWIDTH))
            return c + 8'(PLATE_HALFWIDTH);
        else
            return 8'(Y_MAX);
    endfunction

    // Number of score marks, capped so the row never runs off the screen.
    function automatic logic [5:0] mark_cap(input logic [7:0] s);
        if (s >= 8'(MAX_MARKS))
            return 6'(MAX_MARKS);
        else
            return s[5:0];
    endfunction

    // X position of mark i; fits in 8 bits for every drawable index.
    function automatic logic [7:0] mark_x(input logic [5:0] i);
        return {2'b00, i} * 8'(SCORE_STEP);
    endfunction

    // Scanner state machine with registered beam outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= SNAP;
            cnt         <= '0;
            snap_x      <= '0;
            snap_y      <= '0;
            pmin        <= '0;
            pmax        <= '0;
            pad_y       <= '0;
            marks       <= '0;
            idx         <= '0;
            dac_x       <= '0;
            dac_y       <= '0;
            blank       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                SNAP: begin
                    snap_x      <= x_b;
                    snap_y      <= y_b;
                    pmin        <= paddle_min(y_p_mid);
                    pmax        <= paddle_max(y_p_mid);
                    marks       <= mark_cap(score);
                    idx         <= '0;
                    cnt         <= '0;
                    frame_start <= 1'b1;
                    blank       <= 1'b1;
                    state       <= BALL_MOVE;
                end
                BALL_MOVE: begin
                    blank <= 1'b1;
                    dac_x <= snap_x;
                    dac_y <= snap_y;
                    if (cnt == 5'(SETTLE - 1)) begin
                        cnt   <= '0;
                        state <= BALL;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                BALL: begin
                    blank <= 1'b0;
                    dac_x <= snap_x;
                    dac_y <= snap_y;
                    if (cnt == 5'(BALL_DWELL - 1)) begin
                        cnt   <= '0;
                        state <= PAD_MOVE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                PAD_MOVE: begin
                    blank <= 1'b1;
                    dac_x <= 8'(X_MAX);
                    dac_y <= pmin;
                    if (cnt == 5'(SETTLE - 1)) begin
                        cnt   <= '0;
                        pad_y <= pmin;
                        state <= PAD;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                PAD: begin
                    blank <= 1'b0;
                    dac_x <= 8'(X_MAX);
                    dac_y <= pad_y;
                    if (pad_y == pmax) begin
                        idx   <= '0;
                        state <= (marks == 6'd0) ? SNAP : MARK_MOVE;
                    end else begin
                        pad_y <= pad_y + 8'd1;
                    end
                end
                MARK_MOVE: begin
                    blank <= 1'b1;
                    dac_x <= mark_x(idx);
                    dac_y <= 8'(SCORE_Y);
                    if (cnt == 5'(SETTLE - 1)) begin
                        cnt   <= '0;
                        state <= MARK;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                MARK: begin
                    blank <= 1'b0;
                    dac_x <= mark_x(idx);
                    dac_y <= 8'(SCORE_Y) + {6'd0, cnt[1:0]};
                    if (cnt == 5'd3) begin
                        cnt <= '0;
                        if ((idx + 6'd1) == marks) begin
                            state <= SNAP;
                        end else begin
                            idx   <= idx + 6'd1;
                            state <= MARK_MOVE;
                        end
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: state <= SNAP;
            endcase
        end
    end

endmodule

// File: doc/xy_vector_renderer.md
Name: xy_vector_renderer

Overview:
- Consumer side of the game-state interface: takes ball position, paddle centre and score from the game controller and turns them into an X/Y beam-scan stream for the oscilloscope DACs.
- Runs continuously as a time-multiplexed vector scanner: ball dot, then paddle line, then score tick marks, then repeat.
- Game state is snapshotted once per frame so that a single frame never mixes old and new positions.

Parameters:
X_MAX, 255, x coordinate of the paddle column (right border)
Y_MAX, 220, top of the playfield; paddle clamp limit
PLATE_HALFWIDTH, 15, paddle half-length in y units
BALL_DWELL, 16, unblanked cycles spent on the ball point
SETTLE, 2, blanked cycles spent moving the beam before each segment/mark (1..15)
SCORE_Y, 240, base y of score tick marks
SCORE_STEP, 4, x spacing between score marks
MAX_MARKS, 63, cap on the number of score marks drawn

Ports:
clk  input  1  system clock
reset  input  1  reset, asynchronous, active-high
x_b  input  8  ball x from game controller
y_b  input  8  ball y from game controller
y_p_mid  input  8  paddle centre y
score  input  8  current score
dac_x  output  8  X DAC code
dac_y  output  8  Y DAC code
blank  output  1  1 = beam off (Z-axis blank)
frame_start  output  1  one-cycle pulse in the snapshot cycle

Behaviour:
- Reset (asynchronous) values: dac_x=0, dac_y=0, blank=1, frame_start=0; all snapshot registers 0; state=SNAP.
- All outputs are registered. A state change becomes visible on the outputs one cycle later.
- SNAP (1 cycle):
  - Latch x_b, y_b, y_p_mid, score into snapshot registers.
  - Compute paddle limits:
    - pmin = (y_p_mid >= PLATE_HALFWIDTH) ? y_p_mid-PLATE_HALFWIDTH : 0
    - pmax = (y_p_mid <= Y_MAX-PLATE_HALFWIDTH) ? y_p_mid+PLATE_HALFWIDTH : Y_MAX
  - marks = min(score, MAX_MARKS).
  - Output frame_start=1, blank=1. Next state: BALL_MOVE.
- BALL_MOVE: SETTLE cycles, blank=1, dac=(snap_x, snap_y). Next: BALL.
- BALL: BALL_DWELL cycles, blank=0, dac=(snap_x, snap_y). Next: PAD_MOVE.
- PAD_MOVE: SETTLE cycles, blank=1, dac=(X_MAX, pmin). Next: PAD.
- PAD:
  - blank=0, dac_x=X_MAX, dac_y steps by +1 each cycle from pmin to pmax inclusive: exactly pmax-pmin+1 cycles.
  - Next: SNAP if marks==0, else MARK_MOVE with index i=0.
- MARK_MOVE: SETTLE cycles, blank=1, dac=(i*SCORE_STEP, SCORE_Y). Next: MARK.
- MARK:
  - 4 cycles, blank=0, dac_x=i*SCORE_STEP, dac_y=SCORE_Y+0..3.
  - Then i+1: if it equals marks, go to SNAP; otherwise go to MARK_MOVE.
- Arithmetic:
  - All coordinates are 8-bit.
  - i*SCORE_STEP is computed without overflow for i<=MAX_MARKS-1 (62*4=248).
  - SCORE_Y+3 must be <=255.
- Frame length (cycles, SNAP to next SNAP) = 1 + 2*SETTLE + BALL_DWELL + (pmax-pmin+1) + marks*(SETTLE+4). With defaults and an unclamped paddle: 52 + 6*marks.
- Input changes outside SNAP have no effect until the next SNAP.
- Reset asserted mid-frame: immediate return to reset values. The first SNAP occurs on the first clock edge after deassertion.
- blank is 1 on every cycle where dac_x/dac_y is jumping between discontinuous points; an unblanked jump is never allowed.

Test Plan:
- Release reset with x_b=127, y_b=110, y_p_mid=110, score=0 -> frame_start pulses every 52 cycles. Ball is unblanked at (127,110) for 16 cycles. Paddle is unblanked at x=255, y=95..125 (31 cycles). No score marks.
- score=3, same positions -> frame period 70. Marks are drawn at x=0,4,8, each with y=240..243 unblanked, and each preceded by 2 blanked cycles.
- Paddle clamp: y_p_mid=5 gives paddle y=0..20 (21 cycles). y_p_mid=215 gives y=200..220 (21 cycles). Frame period 42 with score=0.
- score=200 -> exactly 63 marks drawn, the last at x=248. Frame period 52+378=430.
- Change x_b/y_b mid-frame (during PAD) -> the current frame is unchanged; the new ball position appears only after the next frame_start.
- Assert reset during MARK -> within the same cycle blank=1, dac=(0,0), frame_start=0. After release, the first frame_start occurs one cycle after the first clock edge.
